// File: rtl/uart_rx_os8.sv
// Oversampling 8N1 UART receiver driven by an OVERSAMPLE x baud tick strobe.
// Define PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx_os8 #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 CLK100MHZ,
    input  logic                 reset,
    input  logic                 rx_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 framing_err,
    output logic                 busy
`ifdef PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef PARITY_EN
        PARITY,
`endif
        STOP,
        BRK_WAIT
    } state_t;

    state_t                 state_reg;
    logic [TW-1:0]          tick_cnt_reg;
    logic [BW-1:0]          bit_cnt_reg;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rxs;
`ifdef PARITY_EN
    logic                   par_bad_reg;
`endif

    // Presetting to 1 keeps the idle line from looking like a start edge after reset.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
        end
    end

    assign rxs  = sync_reg[SYNC_STAGES-1];
    assign busy = (state_reg != IDLE);

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_reg    <= IDLE;
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            data         <= '0;
            valid        <= 1'b0;
            framing_err  <= 1'b0;
`ifdef PARITY_EN
            parity_err   <= 1'b0;
            par_bad_reg  <= 1'b0;
`endif
        end else begin
            valid       <= 1'b0;
            framing_err <= 1'b0;
`ifdef PARITY_EN
            parity_err  <= 1'b0;
`endif
            if (rx_tick) begin
                case (state_reg)
                    IDLE: begin
                        if (!rxs) begin
                            state_reg    <= START;
                            tick_cnt_reg <= '0;
                        end
                    end
                    START: begin
                        // Mid start bit: a line already back high was only a glitch.
                        if (tick_cnt_reg == HALF_M1) begin
                            tick_cnt_reg <= '0;
                            bit_cnt_reg  <= '0;
                            state_reg    <= rxs ? IDLE : DATA;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                    DATA: begin
                        if (tick_cnt_reg == FULL_M1) begin
                            tick_cnt_reg <= '0;
                            shift_reg    <= {rxs, shift_reg[DATA_BITS-1:1]};
                            if (bit_cnt_reg == LAST_BIT) begin
`ifdef PARITY_EN
                                state_reg <= PARITY;
`else
                                state_reg <= STOP;
`endif
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
`ifdef PARITY_EN
                    PARITY: begin
                        if (tick_cnt_reg == FULL_M1) begin
                            tick_cnt_reg <= '0;
                            par_bad_reg  <= (^shift_reg) ^ rxs;
                            state_reg    <= STOP;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (tick_cnt_reg == FULL_M1) begin
                            tick_cnt_reg <= '0;
                            data         <= shift_reg;
`ifdef PARITY_EN
                            parity_err   <= par_bad_reg;
`endif
                            if (rxs) begin
`ifdef PARITY_EN
                                valid <= ~par_bad_reg;
`else
                                valid <= 1'b1;
`endif
                                state_reg <= IDLE;
                            end else begin
                                framing_err <= 1'b1;
                                state_reg   <= BRK_WAIT;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                    BRK_WAIT: begin
                        // Hold off until the line recovers so a break is reported once.
                        if (rxs) begin
                            state_reg <= IDLE;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os8.sv
// Directed bench for uart_rx_os8: a frame table plus hand-built corner sequences.
// Build with PARITY_EN defined to exercise the parity variant as well.
module tb_uart_rx_os8;

    localparam int OS = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       framing_err;
    logic       busy;
`ifdef PARITY_EN
    logic       parity_err;
    int         perr_cnt = 0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    int div = 4;
    int tick_cnt = 0;

    int valid_cnt = 0;
    int ferr_cnt  = 0;
    int both_cnt  = 0;
    int busy_cnt  = 0;
    logic [7:0] rx_q[$];

    uart_rx_os8 dut (
        .CLK100MHZ  (clk),
        .reset      (reset),
        .rx_tick    (rx_tick),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .framing_err(framing_err),
        .busy       (busy)
`ifdef PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            if (tick_cnt >= div - 1) begin
                tick_cnt = 0;
                rx_tick  = 1'b1;
            end else begin
                tick_cnt = tick_cnt + 1;
                rx_tick  = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (valid) begin
            valid_cnt = valid_cnt + 1;
            rx_q.push_back(data);
        end
        if (framing_err) ferr_cnt = ferr_cnt + 1;
        if (valid && framing_err) both_cnt = both_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
`ifdef PARITY_EN
        if (parity_err) perr_cnt = perr_cnt + 1;
`endif
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (OS * div) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * OS * div) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef PARITY_EN
        drive_bit(par);
`else
        if (par === 1'bx) rx = 1'b1;
`endif
        drive_bit(stop);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         div;
        int         exp_valid;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int bv, bf, bq, bb;

        vecs[0] = '{8'h55, 1'b1, 4, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 4, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 4, 1, 0};
        vecs[3] = '{8'h80, 1'b1, 2, 1, 0};
        vecs[4] = '{8'h01, 1'b1, 1, 1, 0};
        vecs[5] = '{8'hC3, 1'b0, 4, 0, 1};

        repeat (5) @(negedge clk);
        check("reset_data", 32'(data), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_ferr", 32'(framing_err), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        idle_bits(1);

        for (int k = 0; k < 6; k++) begin
            div = vecs[k].div;
            bv = valid_cnt;
            bf = ferr_cnt;
            send_frame(vecs[k].d, vecs[k].stop, ^vecs[k].d);
            idle_bits(3);
            check($sformatf("vec%0d_valid", k), 32'(valid_cnt - bv), 32'(vecs[k].exp_valid));
            check($sformatf("vec%0d_ferr", k), 32'(ferr_cnt - bf), 32'(vecs[k].exp_ferr));
            check($sformatf("vec%0d_data", k), 32'(data), 32'(vecs[k].d));
            check($sformatf("vec%0d_busy", k), 32'(busy), 32'h0);
        end

        // Back-to-back frames with no idle time between stop and start.
        div = 4;
        bv = valid_cnt;
        bq = rx_q.size();
        send_frame(8'hA3, 1'b1, ^8'hA3);
        send_frame(8'h0F, 1'b1, ^8'h0F);
        idle_bits(3);
        check("b2b_valid", 32'(valid_cnt - bv), 32'd2);
        check("b2b_first", 32'(rx_q[bq]), 32'hA3);
        check("b2b_second", 32'(rx_q[bq + 1]), 32'h0F);

        // Start-bit glitch lasting two ticks.
        bv = valid_cnt;
        bf = ferr_cnt;
        bb = busy_cnt;
        rx = 1'b0;
        repeat (2 * div) @(negedge clk);
        idle_bits(2);
        check("glitch_busy_seen", 32'(busy_cnt > bb), 32'd1);
        check("glitch_valid", 32'(valid_cnt - bv), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt - bf), 32'd0);
        check("glitch_busy_end", 32'(busy), 32'h0);

        // Bad stop bit followed by a long break.
        bv = valid_cnt;
        bf = ferr_cnt;
        send_frame(8'hF0, 1'b0, ^8'hF0);
        repeat (30 * div) @(negedge clk);
        check("brk_ferr", 32'(ferr_cnt - bf), 32'd1);
        check("brk_valid", 32'(valid_cnt - bv), 32'd0);
        check("brk_busy_held", 32'(busy), 32'h1);
        check("brk_data", 32'(data), 32'hF0);
        idle_bits(3);
        check("brk_busy_end", 32'(busy), 32'h0);
        check("brk_ferr_once", 32'(ferr_cnt - bf), 32'd1);
        check("brk_no_frame", 32'(valid_cnt - bv), 32'd0);

        // Reset in the middle of data bit 3 of 0x81, then a clean 0x3C.
        bv = valid_cnt;
        bf = ferr_cnt;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rx = 1'b0;
        repeat (OS * div / 2) @(negedge clk);
        reset = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_data", 32'(data), 32'h0);
        reset = 1'b0;
        idle_bits(2);
        check("rst_no_valid", 32'(valid_cnt - bv), 32'd0);
        check("rst_no_ferr", 32'(ferr_cnt - bf), 32'd0);
        send_frame(8'h3C, 1'b1, ^8'h3C);
        idle_bits(3);
        check("rst_next_valid", 32'(valid_cnt - bv), 32'd1);
        check("rst_next_data", 32'(data), 32'h3C);

`ifdef PARITY_EN
        begin
            int bp;
            bv = valid_cnt;
            bf = ferr_cnt;
            bp = perr_cnt;
            send_frame(8'h07, 1'b1, 1'b0);
            idle_bits(3);
            check("par_bad_perr", 32'(perr_cnt - bp), 32'd1);
            check("par_bad_valid", 32'(valid_cnt - bv), 32'd0);
            check("par_bad_data", 32'(data), 32'h07);
            check("par_bad_ferr", 32'(ferr_cnt - bf), 32'd0);
            bv = valid_cnt;
            bp = perr_cnt;
            send_frame(8'h07, 1'b1, 1'b1);
            idle_bits(3);
            check("par_ok_valid", 32'(valid_cnt - bv), 32'd1);
            check("par_ok_perr", 32'(perr_cnt - bp), 32'd0);
        end
`endif

        check("never_both", 32'(both_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
